// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed 32x32 multiply (radix-2 Booth) and
// divide (restoring, on magnitudes) with internal HI/LO result registers.
// Ports:
//   clk        - system clock, rising edge
//   reset_in   - synchronous active-high reset
//   start_mult - one-cycle request: HI:LO = A * B (signed)
//   start_div  - one-cycle request: LO = A / B, HI = A % B (signed)
//   A, B       - operands, latched on the accept edge
//   busy       - operation in progress
//   done       - one-cycle pulse after the result is written
//   div_zero   - last accepted divide had B == 0
//   HI, LO     - result registers
module mult_div_unit (
   input  logic        clk,
   input  logic        reset_in,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_FINISH
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        dz_q, dz_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   // Booth accumulator: 33-bit upper part, 32-bit multiplier, extra bit.
   // The upper part carries one guard bit so that subtracting a
   // multiplicand of -2^31 cannot overflow.
   logic [32:0] mcand_q, mcand_d;
   logic [65:0] acc_q, acc_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [32:0] dvsr_q, dvsr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dzo_q, dzo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [32:0] a_ext, b_ext;
   logic [32:0] a_mag, b_mag;

   // 33-bit magnitudes so |-2^31| is representable
   assign a_ext = {A[31], A};
   assign b_ext = {B[31], B};
   assign a_mag = A[31] ? (33'd0 - a_ext) : a_ext;
   assign b_mag = B[31] ? (33'd0 - b_ext) : b_ext;

   always_comb begin
      logic [32:0] upper;
      logic [32:0] rem_sh;
      logic [33:0] trial;
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      dz_d     = dz_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dzo_d    = dzo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      upper    = acc_q[65:33];
      rem_sh   = {rem_q[31:0], quo_q[31]};
      trial    = {1'b0, rem_sh} - {1'b0, dvsr_q};
      unique case (state_q)
         S_IDLE: begin
            if (start_mult) begin
               state_d  = S_MULT;
               mcand_d  = a_ext;
               acc_d    = {33'd0, B, 1'b0};
               cnt_d    = 5'd0;
               is_div_d = 1'b0;
               dz_d     = 1'b0;
               busy_d   = 1'b1;
               dzo_d    = 1'b0;
            end else if (start_div) begin
               state_d  = S_DIV;
               rem_d    = 33'd0;
               quo_d    = a_mag[31:0];
               dvsr_d   = b_mag;
               qneg_d   = A[31] ^ B[31];
               rneg_d   = A[31];
               dz_d     = (B == 32'd0);
               cnt_d    = 5'd0;
               is_div_d = 1'b1;
               busy_d   = 1'b1;
               dzo_d    = 1'b0;
            end
         end
         S_MULT: begin
            // Booth recoding of the current/previous multiplier bit pair
            if (acc_q[1:0] == 2'b01) begin
               upper = acc_q[65:33] + mcand_q;
            end else if (acc_q[1:0] == 2'b10) begin
               upper = acc_q[65:33] - mcand_q;
            end
            acc_d = 66'($signed({upper, acc_q[32:0]}) >>> 1);
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FINISH;
            end
         end
         S_DIV: begin
            if (dz_q) begin
               state_d = S_FINISH;
            end else begin
               if (trial[33]) begin
                  rem_d = rem_sh;
                  quo_d = {quo_q[30:0], 1'b0};
               end else begin
                  rem_d = trial[32:0];
                  quo_d = {quo_q[30:0], 1'b1};
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_d = S_FINISH;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (is_div_q) begin
               if (dz_q) begin
                  dzo_d = 1'b1;
               end else begin
                  hi_d = rneg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
                  lo_d = qneg_q ? (32'd0 - quo_q) : quo_q;
               end
            end else begin
               hi_d = acc_q[64:33];
               lo_d = acc_q[32:1];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         mcand_q  <= 33'd0;
         acc_q    <= 66'd0;
         rem_q    <= 33'd0;
         quo_q    <= 32'd0;
         dvsr_q   <= 33'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dzo_q    <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         dz_q     <= dz_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dzo_q    <= dzo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dzo_q;
   assign HI       = hi_q;
   assign LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench for mult_div_unit; expected
// results are queued at issue and checked by a done-driven monitor.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset_in;
   logic        start_mult;
   logic        start_div;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks   = 0;
   int failures = 0;

   logic [64:0] exp_q[$];

   mult_div_unit dut (
      .clk        (clk),
      .reset_in   (reset_in),
      .start_mult (start_mult),
      .start_div  (start_div),
      .A          (A),
      .B          (B),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .HI         (HI),
      .LO         (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [64:0] act,
                      input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued result
   always @(negedge clk) begin
      if (!reset_in && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: HI=%h LO=%h", HI, LO);
         end else begin
            chk("result", {HI, LO, div_zero}, exp_q.pop_front());
         end
      end
   end

   // Issue one operation and wait (bounded) for done.
   // inj > 0 pulses start_div during busy cycle inj.
   task automatic do_op(input string name, input logic sm,
                        input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input logic edz,
                        input int ebusy, input int inj);
      int  n;
      bit  seen;
      exp_q.push_back({eh, el, edz});
      @(negedge clk);
      start_mult = sm;
      start_div  = sd;
      A = a;
      B = b;
      @(negedge clk);
      start_mult = 1'b0;
      start_div  = 1'b0;
      A = $urandom;
      B = $urandom;
      chk({name, "_dz_clear"}, {64'd0, div_zero}, 65'd0);
      n    = 0;
      seen = 0;
      for (int i = 0; i < 45; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) n++;
         start_div = (inj > 0 && n == inj);
         @(negedge clk);
      end
      start_div = 1'b0;
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: no done within 45 cycles", name);
      end
      chk({name, "_busy"}, 65'(n), 65'(ebusy));
   endtask

   initial begin
      reset_in   = 1'b1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      A = 32'd0;
      B = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_state", {busy, done, div_zero, HI, LO}, 67'd0);
      reset_in = 1'b0;

      do_op("mul_6x7", 1, 0, 32'd6, 32'd7,
            32'h0, 32'h2A, 0, 33, 0);
      do_op("mul_m1x1", 1, 0, 32'hFFFFFFFF, 32'd1,
            32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33, 0);
      do_op("mul_min2", 1, 0, 32'h80000000, 32'h80000000,
            32'h40000000, 32'h0, 0, 33, 0);
      do_op("div_m7_2", 0, 1, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, 0);
      do_op("div_7_m2", 0, 1, 32'd7, 32'hFFFFFFFE,
            32'h1, 32'hFFFFFFFD, 0, 33, 0);
      do_op("div_min_m1", 0, 1, 32'h80000000, 32'hFFFFFFFF,
            32'h0, 32'h80000000, 0, 33, 0);
      do_op("div_100_7", 0, 1, 32'd100, 32'd7,
            32'd2, 32'd14, 0, 33, 0);
      // 0x66 * 0x2AAAAAAB = 0x00000011_00000022
      do_op("preload", 1, 0, 32'h66, 32'h2AAAAAAB,
            32'h11, 32'h22, 0, 33, 0);
      do_op("div_zero", 0, 1, 32'd5, 32'd0,
            32'h11, 32'h22, 1, 2, 0);
      repeat (3) @(negedge clk);
      chk("dz_held", {64'd0, div_zero}, 65'd1);
      do_op("mul_3xm4", 1, 0, 32'd3, 32'hFFFFFFFC,
            32'hFFFFFFFF, 32'hFFFFFFF4, 0, 33, 0);
      do_op("ignored_div", 1, 0, 32'd5, 32'd5,
            32'h0, 32'd25, 0, 33, 10);
      do_op("both_starts", 1, 1, 32'd9, 32'hFFFFFFFD,
            32'hFFFFFFFF, 32'hFFFFFFE5, 0, 33, 0);
      repeat (3) @(negedge clk);
      chk("hi_lo_stable", {1'b0, HI, LO},
          {1'b0, 32'hFFFFFFFF, 32'hFFFFFFE5});

      // Reset in busy cycle 15 of a divide: no done may follow
      @(negedge clk);
      start_div = 1'b1;
      A = 32'd1000;
      B = 32'd3;
      @(negedge clk);
      start_div = 1'b0;
      repeat (14) @(negedge clk);
      chk("busy_before_rst", {64'd0, busy}, 65'd1);
      reset_in = 1'b1;
      @(negedge clk);
      chk("mid_reset", {busy, done, div_zero, HI, LO}, 67'd0);
      reset_in = 1'b0;
      repeat (45) @(negedge clk);
      chk("idle_after_rst", {busy, done, HI, LO}, 66'd0);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_results: got %0d expected 0",
                  exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS datapath, driven by `ctrl_unit` for `mult` and `div` (R-type, funct 011000 / 011010). It takes operands from the A/B registers, iterates one bit per clock, and holds the 64-bit result in internal HI/LO registers. `mfhi` and `mflo` read those registers through the write-data mux. The control unit pulses a start line, then waits on `done` before returning to FETCH.

## Interface
- No parameters; width is fixed at 32 bits.
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset_in` in 1: synchronous, active-high reset.
- `start_mult` in 1: one-cycle request for a signed multiply, A × B.
- `start_div` in 1: one-cycle request for a signed divide, A ÷ B.
- `A` in 32: operand; multiplicand or dividend.
- `B` in 32: operand; multiplier or divisor.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse when the result is written or the divide is aborted.
- `div_zero` out 1: the last divide had B = 0. Held until the next accepted start.
- `HI` out 32: product high word, or divide remainder.
- `LO` out 32: product low word, or divide quotient.

## Operation
- **Reset values:** state IDLE; `busy`=0, `done`=0, `div_zero`=0, `HI`=0, `LO`=0; counter=0.
- **States:** IDLE, MULT, DIV, FINISH.
- **IDLE**
  - `start_mult`=1 latches A and B and goes to MULT.
  - Otherwise `start_div`=1 latches A and B and goes to DIV.
  - If both are high, multiply wins and `start_div` is ignored.
  - Accepting either start clears `div_zero`.
- **MULT:** radix-2 Booth.
  - 64-bit product accumulator plus one extra bit; arithmetic right shift each cycle.
  - 32 iterations; counter runs 0 to 31, then goes to FINISH.
- **DIV:** restoring division on magnitudes.
  - |A| and |B| taken in 33-bit arithmetic, so |−2^31| is representable.
  - 32 iterations, then FINISH.
  - Quotient sign is A[31] XOR B[31]; remainder sign follows A (truncate toward zero, MIPS semantics).
  - −2^31 ÷ −1 gives LO=0x80000000, HI=0 (two's-complement wrap; no trap).
- **Divide by zero:** if B = 0 when the divide is accepted, DIV does no iteration and goes to FINISH on the next edge. FINISH then sets `div_zero`=1 and leaves HI/LO unchanged.
- **FINISH:** writes HI/LO (except on divide-by-zero), asserts `done` for exactly one cycle, clears `busy`, returns to IDLE.
- **Start while busy or in FINISH:** ignored. No queuing; operands are not re-latched.
- **Inputs A/B:** may change freely after the accept edge; only the latched copies are used.
- **HI/LO:** change only on a FINISH edge (or reset). They are stable at all other times, including during a new operation.
- **Reset mid-operation:** aborts on the next edge and applies all reset values. HI/LO return to 0, and no `done` pulse is produced.

## Timing
- Edge E0 accepts a start. `busy`=1 from after E0.
- **Multiply / normal divide**
  - Iterations occur at edges E1 to E32.
  - Edge E33 is FINISH: HI/LO are written, `done`=1 and `busy`=0 during the cycle after E33.
  - Latency from start edge to `done` visible is 33 cycles.
  - `done` drops after E34.
- **Divide by zero**
  - E1 moves DIV to FINISH.
  - E2: `done`=1, `div_zero`=1, `busy`=0.
  - Latency is 2 cycles.
- **Back-to-back:** the earliest next accept is on the edge where `done` is visible, i.e. the cycle after FINISH. That start is accepted because the unit is then IDLE.
- **Outputs:** all registered; no combinational path from any input to any output.

## Test plan
- **Multiply 6 × 7:** `start_mult` at E0 with A=6, B=7 → `done` after E33; HI=0x00000000, LO=0x0000002A; `busy` high for exactly 33 cycles.
- **Multiply extremes:**
  - A=0xFFFFFFFF (−1), B=1 → HI=0xFFFFFFFF, LO=0xFFFFFFFF.
  - A=B=0x80000000 → HI=0x40000000, LO=0x00000000.
- **Divide signs:**
  - A=−7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=7, B=−2 → LO=0xFFFFFFFD, HI=0x00000001.
  - A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** preload HI=0x11, LO=0x22 via a prior multiply; then divide A=5, B=0 → `done` and `div_zero` after E2; HI/LO unchanged. A following multiply clears `div_zero` on its accept edge.
- **Ignored start:** assert `start_div` at cycle 10 of a multiply, and both starts together in IDLE → the multiply result is unaffected and only one `done` pulse occurs. With both starts, the multiply executes.
- **Reset mid-operation:** `reset_in` at cycle 15 of a divide → after that edge `busy`=0, `done`=0, HI=LO=0, and no `done` pulse afterwards.
